// File: rtl/nibble_serial_add_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// nibble_serial_add_ctrl
//
// Bit-serial-by-nibble adder/subtractor. One 4-bit ripple-carry adder is reused
// for NIB = WIDTH/4 cycles, least-significant nibble first. The inter-nibble
// carry lives in a register, so nothing is computed combinationally across the
// full width.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (in_ready high only in IDLE)
//   A, B              WIDTH-bit operands
//   Cin               carry-in for add (ignored when Sub=1)
//   Sub               1 = A - B (B inverted, carry-in forced to 1)
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   Sum, Cout         result and carry out of the MSB (Sub: 1 = no borrow)
//   Overflow          two's-complement signed overflow
//   busy              high in RUN or DONE
// -----------------------------------------------------------------------------

// 4-bit ripple-carry adder slice.
module nibble_serial_add_ctrl_add4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic c;

  // NOTE: combinational logic uses blocking assignments and gives every output
  // a default first, so no path leaves a value unassigned and no latch forms.
  always_comb begin
    s_o = '0;
    c   = c_i;
    for (int i = 0; i < 4; i++) begin
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    c_o = c;
  end
endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Overflow,
  output logic             busy
);
  localparam int NIB   = WIDTH / 4;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_bad_width
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;   // operands, consumed 4 bits per cycle
  logic [WIDTH-1:0] sum_sh_q;         // result assembled MSB-in
  logic [WIDTH-1:0] sum_q;            // presented result, stable until next op
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             msb_a_q, msb_b_q; // sign bits of A and the (possibly inverted) B
  logic             cout_q, ovf_q;

  logic [3:0]       nib_sum;
  logic             nib_cout;
  logic [WIDTH-1:0] sum_d;

  nibble_serial_add_ctrl_add4 u_add4 (
    .a_i (a_sh_q[3:0]),
    .b_i (b_sh_q[3:0]),
    .c_i (carry_q),
    .s_o (nib_sum),
    .c_o (nib_cout)
  );

  // New nibble enters at the top; after NIB shifts the LSB nibble is at [3:0].
  assign sum_d = WIDTH'({nib_sum, sum_sh_q} >> 4);

  // NOTE: sequential state uses non-blocking assignments only, and every
  // register (operands included) is reset so an aborted operation leaves no
  // residue behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      sum_sh_q <= '0;
      sum_q    <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      msb_a_q  <= 1'b0;
      msb_b_q  <= 1'b0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_sh_q  <= A;
            b_sh_q  <= Sub ? ~B : B;
            carry_q <= Sub ? 1'b1 : Cin;
            msb_a_q <= A[WIDTH-1];
            msb_b_q <= Sub ? ~B[WIDTH-1] : B[WIDTH-1];
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          sum_sh_q <= sum_d;
          carry_q  <= nib_cout;
          a_sh_q   <= a_sh_q >> 4;
          b_sh_q   <= b_sh_q >> 4;
          cnt_q    <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            sum_q   <= sum_d;
            cout_q  <= nib_cout;
            // Overflow: operands share a sign and the result sign differs.
            ovf_q   <= (msb_a_q == msb_b_q) && (nib_sum[3] != msb_a_q);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Overflow  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
`timescale 1ns/1ps
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // WIDTH=32 instance
  logic        iv, ir, cin, sub, ov, ordy, cout, ovf, busy;
  logic [31:0] a, b, sum;
  // WIDTH=4 instance
  logic        iv4, ir4, cin4, sub4, ov4, ordy4, cout4, ovf4, busy4;
  logic [3:0]  a4, b4, sum4;

  int vectors     = 0;
  int miscompares = 0;

  nibble_serial_add_ctrl #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv), .in_ready(ir), .A(a), .B(b),
    .Cin(cin), .Sub(sub), .out_valid(ov), .out_ready(ordy), .Sum(sum),
    .Cout(cout), .Overflow(ovf), .busy(busy));

  nibble_serial_add_ctrl #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .A(a4), .B(b4),
    .Cin(cin4), .Sub(sub4), .out_valid(ov4), .out_ready(ordy4), .Sum(sum4),
    .Cout(cout4), .Overflow(ovf4), .busy(busy4));

  // Reference: plain integer arithmetic on the operands' unsigned and signed values.
  function automatic void ref_model(input int w, input longint unsigned av,
                                    input longint unsigned bv, input bit cv, input bit sv,
                                    output longint unsigned s, output bit co, output bit of);
    longint unsigned modv = 64'd1 << w;
    longint half = longint'(modv >> 1);
    longint sa, sb, exact;
    sa = (av >= (modv >> 1)) ? longint'(av) - longint'(modv) : longint'(av);
    sb = (bv >= (modv >> 1)) ? longint'(bv) - longint'(modv) : longint'(bv);
    if (sv) begin
      exact = sa - sb;
      s     = (av - bv) & (modv - 1);
      co    = (av >= bv);
    end else begin
      exact = sa + sb + longint'(cv);
      s     = (av + bv + cv) & (modv - 1);
      co    = ((av + bv + cv) >= modv);
    end
    of = (exact >= half) || (exact < -half);
  endfunction

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  // One operation on the 32-bit instance: latency, in_ready window and result.
  task automatic run_op32(input logic [31:0] ta, input logic [31:0] tb_v,
                          input bit tc, input bit ts, input string name);
    int n;
    bit bad_ready;
    longint unsigned es;
    bit ec, eo;
    ref_model(32, ta, tb_v, tc, ts, es, ec, eo);
    n = 0;
    while (ir !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    a = ta; b = tb_v; cin = tc; sub = ts; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
    n = 0; bad_ready = 1'b0;
    while (ov !== 1'b1 && n < 40) begin
      if (ir !== 1'b0) bad_ready = 1'b1;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n != 8) begin miscompares++; $display("FAIL %s latency: got %0d want 8", name, n); end
    vectors++;
    if (bad_ready) begin miscompares++; $display("FAIL %s in_ready during run: got high want low", name); end
    vectors++;
    if (sum !== es[31:0]) begin miscompares++; $display("FAIL %s sum: got %h want %h", name, sum, es[31:0]); end
    vectors++;
    if (cout !== ec) begin miscompares++; $display("FAIL %s cout: got %b want %b", name, cout, ec); end
    vectors++;
    if (ovf !== eo) begin miscompares++; $display("FAIL %s overflow: got %b want %b", name, ovf, eo); end
    if (ordy) begin
      @(negedge clk);
      vectors++;
      if (ir !== 1'b1 || ov !== 1'b0) begin
        miscompares++;
        $display("FAIL %s return to idle: got in_ready=%b out_valid=%b want 1/0", name, ir, ov);
      end
    end
  endtask

  task automatic run_op4(input logic [3:0] ta, input logic [3:0] tb_v,
                         input bit tc, input bit ts, input string name);
    int n;
    longint unsigned es;
    bit ec, eo;
    ref_model(4, ta, tb_v, tc, ts, es, ec, eo);
    n = 0;
    while (ir4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    a4 = ta; b4 = tb_v; cin4 = tc; sub4 = ts; iv4 = 1'b1;
    @(negedge clk);
    iv4 = 1'b0;
    n = 0;
    while (ov4 !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    vectors++;
    if (n != 1) begin miscompares++; $display("FAIL %s latency: got %0d want 1", name, n); end
    vectors++;
    if (sum4 !== es[3:0] || cout4 !== ec || ovf4 !== eo) begin
      miscompares++;
      $display("FAIL %s result: got sum=%h c=%b v=%b want sum=%h c=%b v=%b",
               name, sum4, cout4, ovf4, es[3:0], ec, eo);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    iv = 0; a = '0; b = '0; cin = 0; sub = 0; ordy = 1'b1;
    iv4 = 0; a4 = '0; b4 = '0; cin4 = 0; sub4 = 0; ordy4 = 1'b1;
    #3;
    vectors++;
    if (ir !== 1'b1 || ov !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL reset handshake: got rdy=%b vld=%b busy=%b want 1/0/0", ir, ov, busy);
    end
    vectors++;
    if (sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      miscompares++; $display("FAIL reset outputs: got sum=%h c=%b v=%b want 0", sum, cout, ovf);
    end
    vectors++;
    if (ir4 !== 1'b1 || ov4 !== 1'b0 || sum4 !== 4'h0) begin
      miscompares++; $display("FAIL reset w4: got rdy=%b vld=%b sum=%h want 1/0/0", ir4, ov4, sum4);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    run_op32(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0, "add_small");
    run_op32(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, "carry_chain");
    run_op32(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, "pos_overflow");
    run_op32(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, "sub_borrow");
    run_op32(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, "sub_overflow");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++)
      run_op32(pick32(), pick32(), 1'($urandom), 1'($urandom), "random");
  endtask

  task automatic test_backpressure();
    longint unsigned es;
    bit ec, eo;
    ref_model(32, 32'h1357_9BDF, 32'h8642_0000, 1'b1, 1'b0, es, ec, eo);
    ordy = 1'b0;
    run_op32(32'h1357_9BDF, 32'h8642_0000, 1'b1, 1'b0, "bp_op");
    for (int i = 0; i < 5; i++) begin
      a = $urandom; b = $urandom; cin = 1'($urandom); sub = 1'($urandom);
      iv = (i % 2 == 0);
      @(negedge clk);
      vectors++;
      if (ov !== 1'b1 || ir !== 1'b0 || sum !== es[31:0] || cout !== ec || ovf !== eo) begin
        miscompares++;
        $display("FAIL bp_hold: got vld=%b rdy=%b sum=%h c=%b v=%b want 1/0/%h/%b/%b",
                 ov, ir, sum, cout, ovf, es[31:0], ec, eo);
      end
    end
    iv = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    vectors++;
    if (ir !== 1'b1 || ov !== 1'b0 || sum !== es[31:0]) begin
      miscompares++;
      $display("FAIL bp_release: got rdy=%b vld=%b sum=%h want 1/0/%h", ir, ov, sum, es[31:0]);
    end
    run_op32(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, 1'b0, "bp_next");
  endtask

  task automatic test_reset_mid_op();
    int seen;
    while (ir !== 1'b1) @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h1111_2222; cin = 0; sub = 0; iv = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (ov !== 1'b0 || busy !== 1'b0 || ir !== 1'b1 || sum !== 32'h0 || cout !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset: got vld=%b busy=%b rdy=%b sum=%h c=%b v=%b want 0/0/1/0/0/0",
               ov, busy, ir, sum, cout, ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (ov === 1'b1) seen++;
    end
    vectors++;
    if (seen != 0) begin miscompares++; $display("FAIL mid_reset ghost out_valid: got %0d cycles want 0", seen); end
    run_op32(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_width4();
    run_op4(4'h9, 4'h9, 1'b0, 1'b0, "w4_9p9");
    for (int i = 0; i < 16; i++)
      run_op4(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), "w4_random");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_op();
    test_width4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
